// File: rtl/snowflake_motion_ctrl.sv
// -----------------------------------------------------------------------------
// snowflake_motion_ctrl
//
// Bus initiator for the snowflake sprite core's video slot write interface.
// After reset it streams a generated 32x32 2-bit snowflake bitmap into sprite
// RAM, then configures bypass and colour and writes the initial position.
// From then on, each frame tick (first blanking line, column 0) advances the
// sprite: it falls by SPEED, and on every vertical wrap it drifts sideways by
// DRIFT. The new x0/y0 values are written back to the core.
//
// Ports
//   clk      in   1   system clock
//   reset    in   1   synchronous, active-high reset
//   enable   in   1   1 = advance position on frame ticks, 0 = hold
//   x, y     in   11  frame counter column / row
//   cs       out  1   slot select (always equal to write)
//   write    out  1   write strobe, one cycle per write
//   addr     out  14  [13]=0 RAM word, [13]=1 register (00 byp, 01 x0, 10 y0, 11 ctrl)
//   wr_data  out  32  write data
//   done     out  1   high once bitmap load and configuration are complete
// -----------------------------------------------------------------------------
module snowflake_motion_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int SPEED      = 2,
    parameter int DRIFT      = 3,
    parameter int X_INIT     = 100,
    parameter int X_MAX      = 607,
    parameter int Y_MAX      = 479,
    parameter int V_TRIG     = 480,
    parameter int COLOR      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [10:0] x,
    input  logic [10:0] y,
    output logic        cs,
    output logic        write,
    output logic [13:0] addr,
    output logic [31:0] wr_data,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_CFG_BYP,
        ST_CFG_CTRL,
        ST_WR_X,
        ST_WR_Y,
        ST_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [11:0]             x_pos_q, x_pos_d;
    logic [11:0]             y_pos_q, y_pos_d;
    logic                    cs_q, cs_d;
    logic [13:0]             addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic                    done_q, done_d;

    // Bitmap generator: cnt = {row, col}; a pixel is lit on the centre row,
    // the centre column and both diagonals.
    logic [4:0] row, col;
    logic [5:0] row_col_sum;
    logic [1:0] pix;

    assign row         = cnt_q[9:5];
    assign col         = cnt_q[4:0];
    assign row_col_sum = {1'b0, row} + {1'b0, col};
    assign pix = ((row == 5'd15) || (col == 5'd15) || (row == col) || (row_col_sum == 6'd31))
                 ? 2'b01 : 2'b00;

    // Frame tick and next position. A tick is accepted only once the bus is
    // idle in WAIT, so the y0 write of the previous update has drained.
    logic        tick;
    logic        accept;
    logic [11:0] y_n, x_n, x_wrapped;

    assign tick      = (x == 11'd0) && (y == 11'(V_TRIG));
    assign accept    = (state_q == ST_WAIT) && !cs_q && tick && enable;
    assign y_n       = y_pos_q + 12'(SPEED);
    assign x_n       = x_pos_q + 12'(DRIFT);
    assign x_wrapped = (x_n > 12'(X_MAX)) ? (x_n - 12'(X_MAX) - 12'd1) : x_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_pos_d = x_pos_q;
        y_pos_d = y_pos_q;
        cs_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;

        case (state_q)
            ST_LOAD: begin
                cs_d   = 1'b1;
                addr_d = {1'b0, 13'(cnt_q)};
                data_d = {30'b0, pix};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_CFG_BYP;
                end
            end
            ST_CFG_BYP: begin
                cs_d    = 1'b1;
                addr_d  = 14'h2000;
                data_d  = 32'd0;
                state_d = ST_CFG_CTRL;
            end
            ST_CFG_CTRL: begin
                cs_d    = 1'b1;
                addr_d  = 14'h2003;
                data_d  = 32'(COLOR);
                state_d = ST_WR_X;
            end
            ST_WR_X: begin
                cs_d    = 1'b1;
                addr_d  = 14'h2001;
                data_d  = 32'(x_pos_q);
                state_d = ST_WR_Y;
            end
            ST_WR_Y: begin
                cs_d    = 1'b1;
                addr_d  = 14'h2002;
                data_d  = 32'(y_pos_q);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                done_d = 1'b1;
                if (accept) begin
                    // The x0 write goes out on the very next cycle, so it is
                    // issued straight from WAIT with the updated value; the
                    // FSM then continues with the y0 write.
                    if (y_n > 12'(Y_MAX)) begin
                        y_pos_d = 12'd0;
                        x_pos_d = x_wrapped;
                        data_d  = 32'(x_wrapped);
                    end else begin
                        y_pos_d = y_n;
                        data_d  = 32'(x_pos_q);
                    end
                    cs_d    = 1'b1;
                    addr_d  = 14'h2001;
                    state_d = ST_WR_Y;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            x_pos_q <= 12'(X_INIT);
            y_pos_q <= 12'd0;
            cs_q    <= 1'b0;
            addr_q  <= 14'd0;
            data_q  <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_pos_q <= x_pos_d;
            y_pos_q <= y_pos_d;
            cs_q    <= cs_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign cs      = cs_q;
    assign write   = cs_q;
    assign addr    = addr_q;
    assign wr_data = data_q;
    assign done    = done_q;

endmodule

// File: tb/tb_snowflake_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snowflake_motion_ctrl
//
// Two controllers share all inputs: one with default parameters and one
// starting at x0=600 so the horizontal wrap is reached in a few vertical
// wraps. Every bus write is compared against a queue of expected writes
// produced by a behavioural position/bitmap model.
// -----------------------------------------------------------------------------
module tb_snowflake_motion_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [10:0] x_in = 11'd1;
    logic [10:0] y_in = 11'd0;

    logic        cs0, wr0, done0;
    logic [13:0] addr0;
    logic [31:0] data0;
    logic        cs1, wr1, done1;
    logic [13:0] addr1;
    logic [31:0] data1;

    always #5 clk = ~clk;

    snowflake_motion_ctrl u_dut0 (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .x       (x_in),
        .y       (y_in),
        .cs      (cs0),
        .write   (wr0),
        .addr    (addr0),
        .wr_data (data0),
        .done    (done0)
    );

    snowflake_motion_ctrl #(.X_INIT(600)) u_dut1 (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .x       (x_in),
        .y       (y_in),
        .cs      (cs1),
        .write   (wr1),
        .addr    (addr1),
        .wr_data (data1),
        .done    (done1)
    );

    int          total = 0;
    int          bad = 0;
    logic [45:0] q0[$];
    logic [45:0] q1[$];
    int          writes0 = 0;
    int          writes1 = 0;
    logic [31:0] last_x[2];
    logic [31:0] last_y[2];
    int          x_m[2];
    int          y_m[2];
    int          x_init[2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [13:0] a, input logic [31:0] d);
        if (k == 0) q0.push_back({a, d});
        else        q1.push_back({a, d});
    endtask

    // Observe one DUT's bus for the current cycle.
    task automatic mon(input int k, input logic c, input logic w,
                       input logic [13:0] a, input logic [31:0] d);
        logic [45:0] e;
        logic        have;
        if (c || w) begin
            check_eq("cs_eq_write", 32'(c), 32'(w));
            have = 1'b0;
            e = '0;
            if (k == 0) begin
                writes0++;
                if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            end else begin
                writes1++;
                if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            end
            if (!have) begin
                check_eq("spurious_cs", 32'(c), 32'd0);
            end else begin
                check_eq("wr_addr", 32'(a), 32'(e[45:32]));
                check_eq("wr_data", d, e[31:0]);
                if (a == 14'h2001) last_x[k] = d;
                if (a == 14'h2002) last_y[k] = d;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon(0, cs0, wr0, addr0, data0);
        mon(1, cs1, wr1, addr1, data1);
    endtask

    // Expected power-up write stream: bitmap, bypass, colour, x0, y0.
    task automatic push_load();
        int r, c;
        logic [31:0] p;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1024; i++) begin
                r = i / 32;
                c = i % 32;
                p = (r == 15 || c == 15 || r == c || r + c == 31) ? 32'd1 : 32'd0;
                push_exp(k, 14'(i), p);
            end
            push_exp(k, 14'h2000, 32'd0);
            push_exp(k, 14'h2003, 32'd1);
            push_exp(k, 14'h2001, 32'(x_init[k]));
            push_exp(k, 14'h2002, 32'd0);
        end
    endtask

    // Reference position update for one accepted frame tick.
    task automatic model_tick();
        int yn, xn;
        for (int k = 0; k < 2; k++) begin
            yn = y_m[k] + 2;
            if (yn > 479) begin
                y_m[k] = 0;
                xn = x_m[k] + 3;
                x_m[k] = (xn > 607) ? xn - 608 : xn;
            end else begin
                y_m[k] = yn;
            end
            push_exp(k, 14'h2001, 32'(x_m[k]));
            push_exp(k, 14'h2002, 32'(y_m[k]));
        end
    endtask

    task automatic reset_dut();
        reset  = 1'b1;
        enable = 1'b0;
        x_in   = 11'd1;
        y_in   = 11'd0;
        repeat (3) step();
        check_eq("rst_cs",   32'(cs0),   32'd0);
        check_eq("rst_wr",   32'(wr0),   32'd0);
        check_eq("rst_addr", 32'(addr0), 32'd0);
        check_eq("rst_data", data0,      32'd0);
        check_eq("rst_done", 32'(done0), 32'd0);
        check_eq("rst_cs1",  32'(cs1),   32'd0);
        q0.delete();
        q1.delete();
        writes0 = 0;
        writes1 = 0;
        for (int k = 0; k < 2; k++) begin
            x_m[k] = x_init[k];
            y_m[k] = 0;
        end
    endtask

    // Release reset and follow the load sequence; abort_at > 0 reasserts
    // reset while that cycle's write is on the bus.
    task automatic load_seq(input int abort_at);
        logic finished;
        logic aborted;
        finished = 1'b0;
        aborted  = 1'b0;
        push_load();
        reset = 1'b0;
        for (int n = 1; n <= 2000; n++) begin
            step();
            if (n == 1) begin
                check_eq("first_wr_cs",   32'(cs0),   32'd1);
                check_eq("first_wr_addr", 32'(addr0), 32'd0);
            end
            if (n == 300) begin
                x_in = 11'd0; y_in = 11'd480; enable = 1'b1;
            end
            if (n == 301) begin
                x_in = 11'd1; y_in = 11'd0; enable = 1'b0;
            end
            if (n == 500) check_eq("load_done_lo", 32'(done0), 32'd0);
            if (n == abort_at) begin
                check_eq("abort_addr_pre", 32'(addr0), 32'(abort_at - 1));
                reset = 1'b1;
                step();
                check_eq("abort_cs",   32'(cs0),   32'd0);
                check_eq("abort_done", 32'(done0), 32'd0);
                aborted = 1'b1;
                break;
            end
            if (done0) begin
                check_eq("done_latency", 32'(n), 32'd1029);
                check_eq("done_cs_idle", 32'(cs0), 32'd0);
                check_eq("done1", 32'(done1), 32'd1);
                finished = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            if (!finished) check_eq("done_timeout", 32'(done0), 32'd1);
            check_eq("load_writes0", 32'(writes0), 32'd1028);
            check_eq("load_writes1", 32'(writes1), 32'd1028);
            check_eq("load_q0_left", 32'(q0.size()), 32'd0);
            check_eq("load_q1_left", 32'(q1.size()), 32'd0);
        end
    endtask

    // kind 0: real tick; kind 1/2: near-miss patterns that must not trigger.
    task automatic tick(input int id, input logic en, input int kind);
        logic exp;
        enable = en;
        if (kind == 0)      begin x_in = 11'd0; y_in = 11'd480; end
        else if (kind == 1) begin x_in = 11'd0; y_in = 11'd479; end
        else                begin x_in = 11'd1; y_in = 11'd480; end
        exp = en && (kind == 0);
        if (exp) model_tick();
        step();
        check_eq("tick_n1_cs", 32'(cs0), 32'(exp));
        if (exp) check_eq("tick_n1_addr", 32'(addr0), 32'h2001);
        x_in = 11'd1; y_in = 11'd0; enable = 1'b0;
        step();
        check_eq("tick_n2_cs", 32'(cs0), 32'(exp));
        if (exp) check_eq("tick_n2_addr", 32'(addr0), 32'h2002);
        step();
        check_eq("tick_n3_cs", 32'(cs0), 32'd0);
        step();
        $display("tick %0d en=%0d kind=%0d dut0 x=%0d y=%0d dut1 x=%0d y=%0d",
                 id, en, kind, x_m[0], y_m[0], x_m[1], y_m[1]);
    endtask

    initial begin
        int prev_x1;
        x_init[0] = 100;
        x_init[1] = 600;
        last_x[0] = '0; last_x[1] = '0;
        last_y[0] = '0; last_y[1] = '0;

        reset_dut();
        load_seq(0);

        tick(1, 1'b1, 0);
        check_eq("first_tick_x", last_x[0], 32'd100);
        check_eq("first_tick_y", last_y[0], 32'd2);
        for (int i = 2; i <= 240; i++) begin
            tick(i, 1'b1, 0);
            if (i == 239) check_eq("y_pre_wrap", last_y[0], 32'd478);
        end
        check_eq("wrap_x", last_x[0], 32'd103);
        check_eq("wrap_y", last_y[0], 32'd0);
        check_eq("wrap_x1", last_x[1], 32'd603);

        tick(241, 1'b0, 0);
        check_eq("hold_y", last_y[0], 32'd0);

        for (int i = 0; i < 800; i++) begin
            int r;
            logic en;
            int kind;
            r    = int'($urandom_range(0, 5));
            kind = (r < 4) ? 0 : r - 3;
            en   = ($urandom_range(0, 3) != 0);
            prev_x1 = x_m[1];
            tick(242 + i, en, kind);
            if (prev_x1 == 606 && x_m[1] != 606) check_eq("x_wrap_606", last_x[1], 32'd1);
        end
        check_eq("rand_q0_left", 32'(q0.size()), 32'd0);
        check_eq("rand_q1_left", 32'(q1.size()), 32'd0);

        reset_dut();
        load_seq(501);
        reset_dut();
        load_seq(0);
        tick(9999, 1'b1, 0);
        check_eq("post_rst_x", last_x[0], 32'd100);
        check_eq("post_rst_y", last_y[0], 32'd2);
        check_eq("post_rst_x1", last_x[1], 32'd600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
